// File: rtl/demux_buf.sv
// Registered 1-to-2 demultiplexer with a small FIFO per output channel.
// Valid/ready handshakes on the input side and on both output channels.
module demux_buf_chan #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] head_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_inc;
    logic             do_push;
    logic             do_pop;

    // A full channel refuses pushes even when it pops in the same cycle;
    // pop requests are ignored while the channel is empty.
    assign do_push = push && (state != FULL);
    assign do_pop  = pop && (state != EMPTY);
    assign rd_inc  = rd_ptr + PW'(1);

    assign data  = head;
    assign valid = (state != EMPTY);
    assign count = cnt;

    // Occupancy state machine plus the head word that becomes visible next.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        head_nx  = head;
        unique case (state)
            EMPTY: begin
                if (do_push) begin
                    state_nx = PARTIAL;
                    cnt_nx   = cnt + CW'(1);
                    head_nx  = wdata;
                end
            end
            PARTIAL: begin
                if (do_push && !do_pop) begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == CW'(DEPTH - 1)) begin
                        state_nx = FULL;
                    end
                end else if (do_pop && !do_push) begin
                    cnt_nx = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nx = EMPTY;
                    end
                end
                if (do_pop) begin
                    if (cnt > CW'(1)) begin
                        head_nx = mem[rd_inc];
                    end else if (do_push) begin
                        head_nx = wdata;
                    end
                end
            end
            FULL: begin
                if (do_pop) begin
                    state_nx = PARTIAL;
                    cnt_nx   = cnt - CW'(1);
                    head_nx  = mem[rd_inc];
                end
            end
            default: begin
                state_nx = EMPTY;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, count, head and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            cnt    <= '0;
            head   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            head  <= head_nx;
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_inc;
            end
        end
    end

    // Storage array, cleared on reset so old words can never resurface.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end
endmodule

module demux_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out0_data,
    output logic                     out0_valid,
    input  logic                     out0_ready,
    output logic [WIDTH-1:0]         out1_data,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [$clog2(DEPTH):0]   out0_count,
    output logic [$clog2(DEPTH):0]   out1_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic push0;
    logic push1;

    // Ready reflects only the selected channel, so a full channel never
    // blocks traffic headed for the other one.
    assign in_ready = in_sel ? (out1_count != CW'(DEPTH))
                             : (out0_count != CW'(DEPTH));
    assign push0 = in_valid && in_ready && !in_sel;
    assign push1 = in_valid && in_ready && in_sel;

    demux_buf_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .wdata (in_data),
        .pop   (out0_ready),
        .data  (out0_data),
        .valid (out0_valid),
        .count (out0_count)
    );

    demux_buf_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .wdata (in_data),
        .pop   (out1_ready),
        .data  (out1_data),
        .valid (out1_valid),
        .count (out1_count)
    );
endmodule

// File: tb/tb_demux_buf.sv
// Bench for demux_buf: directed scenarios followed by random traffic,
// checked against a queue-based model of the two channels.
module tb_demux_buf;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CW-1:0]    out0_count;
    logic [CW-1:0]    out1_count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] last0 = '0;
    logic [WIDTH-1:0] last1 = '0;

    demux_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        chk("out0_valid", WIDTH'(out0_valid), WIDTH'(q0.size() > 0));
        chk("out1_valid", WIDTH'(out1_valid), WIDTH'(q1.size() > 0));
        chk("out0_count", WIDTH'(out0_count), WIDTH'(q0.size()));
        chk("out1_count", WIDTH'(out1_count), WIDTH'(q1.size()));
        chk("out0_data", out0_data, (q0.size() > 0) ? q0[0] : last0);
        chk("out1_data", out1_data, (q1.size() > 0) ? q1[0] : last1);
    endtask

    // One clock: drive inputs, check in_ready, clock, update model, check.
    task automatic step(input logic rst, input logic v, input logic sel,
                        input logic [WIDTH-1:0] d, input logic r0,
                        input logic r1);
        bit acc;
        rst_n = rst; in_valid = v; in_sel = sel; in_data = d;
        out0_ready = r0; out1_ready = r1;
        #1;
        acc = v && ((sel ? q1.size() : q0.size()) != DEPTH);
        if (rst) begin
            chk("in_ready", WIDTH'(in_ready),
                WIDTH'((sel ? q1.size() : q0.size()) != DEPTH));
        end
        @(posedge clk);
        if (!rst) begin
            q0.delete(); q1.delete();
            last0 = '0; last1 = '0;
        end else begin
            if (r0 && q0.size() > 0) last0 = q0.pop_front();
            if (r1 && q1.size() > 0) last1 = q1.pop_front();
            if (acc) begin
                if (sel) q1.push_back(d);
                else     q0.push_back(d);
            end
        end
        #1;
        check_outs();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = '1;
        out0_ready = 1'b0; out1_ready = 1'b0;

        // Reset held two clocks with a word offered.
        step(0, 1, 0, 32'hFFFF_FFFF, 0, 0);
        step(0, 1, 1, 32'hFFFF_FFFF, 0, 0);
        chk("rst_data0", out0_data, 32'h0);
        chk("rst_cnt1", WIDTH'(out1_count), 32'h0);

        // Routing with 1-cycle latency.
        step(1, 1, 0, 32'hDEAD_BEEF, 1, 1);
        chk("route0", out0_data, 32'hDEAD_BEEF);
        step(1, 1, 1, 32'h1234_5678, 1, 1);
        chk("route1", out1_data, 32'h1234_5678);
        chk("route0_cnt", WIDTH'(out0_count), 32'h0);
        step(1, 0, 0, 32'h0, 1, 1);

        // Fill channel 0, refuse third push, channel 1 still accepts.
        step(1, 1, 0, 32'hA, 0, 0);
        step(1, 1, 0, 32'hB, 0, 0);
        step(1, 1, 0, 32'hC, 0, 0);
        chk("full_cnt0", WIDTH'(out0_count), 32'd2);
        step(1, 1, 1, 32'h1, 0, 0);
        chk("other_ch", WIDTH'(out1_count), 32'd1);

        // Full plus pop: refused, then accepted next cycle.
        in_sel = 1'b0; in_valid = 1'b1; #1;
        chk("full_refuse", WIDTH'(in_ready), 32'd0);
        step(1, 1, 0, 32'hC, 1, 1);
        chk("pop_a", out0_data, 32'hB);
        step(1, 1, 0, 32'hC, 1, 0);
        chk("order_c", out0_data, 32'hC);
        step(1, 0, 0, 32'h0, 1, 0);
        chk("hold_c", out0_data, 32'hC);

        // Steady alternating stream.
        for (int i = 0; i < 16; i++) begin
            step(1, 1, i[0], $urandom, 1, 1);
            checks++;
            assert (out0_count <= 1 && out1_count <= 1) else begin
                errors++;
                $error("FAIL stream_cnt observed=%0d/%0d expected<=1",
                       out0_count, out1_count);
            end
        end
        step(1, 0, 0, 32'h0, 1, 1);

        // Reset mid-operation with both channels full.
        for (int i = 0; i < 4; i++) step(1, 1, i[0], $urandom, 0, 0);
        step(0, 1, 0, 32'h5, 1, 1);
        chk("mid_rst_v0", WIDTH'(out0_valid), 32'd0);
        chk("mid_rst_d1", out1_data, 32'h0);
        step(1, 1, 0, 32'h77, 0, 0);
        chk("post_rst", out0_data, 32'h77);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
